// File: rtl/spi_dac_pkg.sv
// Shared definitions for the MCP49xx SPI DAC streamer: FSM states, frame layout and
// fixed configuration bits.
package spi_dac_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StCsSetup,
    StShift,
    StCsHold,
    StGap,
    StLoad
  } state_e;

  localparam int unsigned FrameW   = 16;
  localparam int unsigned ChanBit  = 15;
  localparam int unsigned BufBit   = 14;
  localparam int unsigned GaNBit   = 13;
  localparam int unsigned ShdnNBit = 12;
  localparam int unsigned CodeW    = 12;

  // Unbuffered reference, 1x gain, output active.
  localparam logic CfgBuf   = 1'b0;
  localparam logic CfgGaN   = 1'b1;
  localparam logic CfgShdnN = 1'b1;

  function automatic logic [FrameW-1:0] build_word(input logic chan,
                                                   input logic [CodeW-1:0] code12);
    logic [FrameW-1:0] w;
    w              = '0;
    w[ChanBit]     = chan;
    w[BufBit]      = CfgBuf;
    w[GaNBit]      = CfgGaN;
    w[ShdnNBit]    = CfgShdnN;
    w[CodeW-1:0]   = code12;
    return w;
  endfunction

endpackage

// File: rtl/spi_dac_tick.sv
// Free-running sample-rate divider: one-cycle tick every RATE_DIV clocks.
module spi_dac_tick #(
  parameter int unsigned RATE_DIV = 5000
) (
  input  logic clk,
  input  logic rst,
  output logic tick
);

  localparam int unsigned CntW = (RATE_DIV > 1) ? $clog2(RATE_DIV) : 1;

  logic [CntW-1:0] cnt_q;

  assign tick = (cnt_q == CntW'(RATE_DIV - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (tick) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + CntW'(1);
    end
  end

endmodule

// File: rtl/spi_dac_stream.sv
// Streams one sample per internal tick to an MCP491x/492x DAC over SPI.
// Define SPI_DAC_STREAM_LDAC_EN to drive a DAC_LD pulse after each frame.
module spi_dac_stream
  import spi_dac_pkg::*;
#(
  parameter int unsigned DATA_W   = 10,
  parameter int unsigned NCH      = 1,
  parameter int unsigned CLK_DIV  = 1,
  parameter int unsigned RATE_DIV = 5000
) (
  input  logic                  CLOCK_50,
  input  logic                  RESET,
  input  logic [NCH*DATA_W-1:0] din,
  input  logic                  din_valid,
  output logic                  din_ready,
  output logic                  DAC_SDI,
  output logic                  DAC_CS,
  output logic                  DAC_SCK,
  output logic                  DAC_LD,
  output logic                  busy,
  output logic                  underrun
);

  localparam int unsigned DivW = $clog2(2 * CLK_DIV) + 1;
  localparam int unsigned Pad  = CodeW - DATA_W;

  logic tick;

  spi_dac_tick #(
    .RATE_DIV(RATE_DIV)
  ) u_tick (
    .clk (CLOCK_50),
    .rst (RESET),
    .tick(tick)
  );

  state_e                state_q, state_d;
  logic [DivW-1:0]       div_q, div_d;
  logic [4:0]            hcnt_q, hcnt_d;
  logic                  chan_q, chan_d;
  logic [FrameW-1:0]     shreg_q, shreg_d;
  logic [NCH*DATA_W-1:0] sample_q, sample_d, last_q, last_d;
  logic                  full_q, full_d, underrun_q, underrun_d;
  logic                  accept, start, load_word, half_done, full_done;
  logic [CodeW-1:0]      code_a12, code_b12;

  assign din_ready = ~full_q;
  assign accept    = din_valid & din_ready;
  assign start     = tick & (state_q == StIdle);
  assign half_done = (div_q == DivW'(CLK_DIV - 1));
  assign full_done = (div_q == DivW'(2 * CLK_DIV - 1));

  // A sample arriving on the tick cycle bypasses the holding register.
  always_comb begin
    last_d     = last_q;
    sample_d   = sample_q;
    full_d     = full_q;
    underrun_d = underrun_q;
    if (start) begin
      if (accept) begin
        last_d = din;
      end else if (full_q) begin
        last_d = sample_q;
        full_d = 1'b0;
      end else begin
        underrun_d = 1'b1;
      end
    end else begin
      if (accept) begin
        sample_d = din;
        full_d   = 1'b1;
      end
      if (tick) underrun_d = 1'b1;
    end
  end

  assign code_a12 = CodeW'(last_d[DATA_W-1:0]) << Pad;
  assign code_b12 = CodeW'(last_d[NCH*DATA_W-1 -: DATA_W]) << Pad;

  always_comb begin
    state_d   = state_q;
    div_d     = div_q + DivW'(1);
    hcnt_d    = hcnt_q;
    chan_d    = chan_q;
    shreg_d   = shreg_q;
    load_word = 1'b0;
    unique case (state_q)
      StIdle: begin
        div_d = '0;
        if (start) begin
          state_d   = StCsSetup;
          chan_d    = 1'b0;
          load_word = 1'b1;
        end
      end
      StCsSetup: begin
        if (half_done) begin
          state_d = StShift;
          div_d   = '0;
          hcnt_d  = '0;
        end
      end
      StShift: begin
        // Even half-periods are SCK low, odd are SCK high; shift on each falling edge.
        if (half_done) begin
          div_d  = '0;
          hcnt_d = hcnt_q + 5'd1;
          if (hcnt_q[0]) shreg_d = shreg_q << 1;
          if (hcnt_q == 5'd31) state_d = StCsHold;
        end
      end
      StCsHold: begin
        if (half_done) begin
          div_d = '0;
          if (NCH > 1 && !chan_q) begin
            state_d = StGap;
            chan_d  = 1'b1;
          end else begin
`ifdef SPI_DAC_STREAM_LDAC_EN
            state_d = StLoad;
`else
            state_d = StIdle;
`endif
          end
        end
      end
      StGap: begin
        if (full_done) begin
          div_d     = '0;
          state_d   = StCsSetup;
          load_word = 1'b1;
        end
      end
      StLoad: begin
        if (full_done) begin
          div_d   = '0;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
    if (load_word) shreg_d = chan_d ? build_word(1'b1, code_b12) : build_word(1'b0, code_a12);
  end

  always_ff @(posedge CLOCK_50) begin
    if (RESET) begin
      state_q    <= StIdle;
      div_q      <= '0;
      hcnt_q     <= '0;
      chan_q     <= 1'b0;
      shreg_q    <= '0;
      sample_q   <= '0;
      last_q     <= '0;
      full_q     <= 1'b0;
      underrun_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      div_q      <= div_d;
      hcnt_q     <= hcnt_d;
      chan_q     <= chan_d;
      shreg_q    <= shreg_d;
      sample_q   <= sample_d;
      last_q     <= last_d;
      full_q     <= full_d;
      underrun_q <= underrun_d;
    end
  end

  logic cs_active;
  assign cs_active = (state_q == StCsSetup) | (state_q == StShift) | (state_q == StCsHold);
  assign DAC_CS    = ~cs_active;
  assign DAC_SCK   = (state_q == StShift) & hcnt_q[0];
  assign DAC_SDI   = cs_active & shreg_q[FrameW-1];
  assign busy      = (state_q != StIdle);
  assign underrun  = underrun_q;

`ifdef SPI_DAC_STREAM_LDAC_EN
  assign DAC_LD = (state_q != StLoad);
`else
  assign DAC_LD = 1'b0;
`endif

endmodule

// File: doc/spi_dac_stream.md
SPI_DAC_STREAM -- requirements
Module: spi_dac_stream

Interface
REQ-001 SHALL have parameter DATA_W, default 10, meaning DAC code width per channel, legal 8/10/12.
REQ-002 SHALL have parameter NCH, default 1, meaning channel count, legal 1 or 2 (MCP491x/MCP492x A/B).
REQ-003 SHALL have parameter CLK_DIV, default 1, meaning CLOCK_50 cycles per SCK half-period, >=1.
REQ-004 SHALL have parameter RATE_DIV, default 5000, meaning CLOCK_50 cycles per sample tick, >= frame length.
REQ-005 SHALL have ports: CLOCK_50 in 1 system clock; RESET in 1 synchronous active-high reset.
REQ-006 SHALL have ports: din in NCH*DATA_W, channel k code at bits [k*DATA_W +: DATA_W]; din_valid in 1; din_ready out 1.
REQ-007 SHALL have ports: DAC_SDI out 1 serial data; DAC_CS out 1 active-low chip select; DAC_SCK out 1 SPI clock; DAC_LD out 1 active-low load.
REQ-008 SHALL have ports: busy out 1 frame in progress; underrun out 1 sticky, tick with no new sample.

Function
REQ-009 SHALL generate an internal tick every RATE_DIV cycles, free-running from reset; this replaces any external divider.
REQ-010 SHALL hold one sample register; din_ready=1 when register empty; din accepted on din_valid&&din_ready, register marked full.
REQ-011 On tick: if full, latch register into shift source, mark empty; if empty, resend last sample and set underrun.
REQ-012 Simultaneous tick and accept: SHALL latch the incoming din for this tick; register stays empty.
REQ-013 FSM states IDLE, CS_SETUP, SHIFT, CS_HOLD, GAP, LOAD; IDLE->CS_SETUP on tick; CS_SETUP->SHIFT after one half-period.
REQ-014 Frame word (16b): bit15 channel (0=A,1=B), bit14 BUF=0, bit13 GA_n=1, bit12 SHDN_n=1, bits11:0 = code left-justified, LSBs zero.
REQ-015 SHIFT: MSB first; SDI changes while SCK low, SCK high for half-period; 16 full SCK periods per word; SCK idles low.
REQ-016 SHIFT->CS_HOLD after 16th falling edge; CS_HOLD lasts one half-period, then CS high.
REQ-017 NCH=2: CS_HOLD->GAP (CS high, 2 half-periods)->CS_SETUP for channel B; after last channel ->LOAD.
REQ-018 LOAD: DAC_LD low for exactly 2*CLK_DIV cycles, then IDLE; busy high from leaving IDLE until IDLE re-entered.
REQ-019 Tick while busy SHALL be ignored (no frame queued) and SHALL set underrun; RATE_DIV sizing makes this a config error.
REQ-020 underrun clears only on RESET.

Reset
REQ-021 RESET SHALL force IDLE, DAC_CS=1, DAC_SCK=0, DAC_SDI=0, DAC_LD=1, busy=0, underrun=0, din_ready=1, tick counter=0, last sample=0.
REQ-022 RESET mid-frame SHALL abort immediately; CS rises next cycle; no LD pulse issued.

Configuration
REQ-023 Macro SPI_DAC_STREAM_LDAC_EN defined: DAC_LD pulsed per REQ-018.
REQ-024 Macro absent: LOAD state skipped, DAC_LD tied 0 (DAC updates on CS rise), frame ends at last CS_HOLD.

Structure
REQ-025 Shared package spi_dac_pkg SHALL hold FSM state enum, frame bit-position constants, config-bit defaults.
REQ-026 Sub-module spi_dac_tick (RATE_DIV counter, one-cycle pulse) SHALL be instantiated; shifter stays in top.

Verification (DATA_W=10, NCH=2, CLK_DIV=1, RATE_DIV=100, LDAC_EN defined)
REQ-027 Post-reset, no din -> first tick sends 0x3000 then 0xB000, underrun=1.
REQ-028 din={B=0x155,A=0x3FF} valid -> words 0x3FFC then 0xB554 on SDI sampled at SCK rise; LD low 2 cycles after second CS rise.
REQ-029 Two samples pushed before tick -> second held off by din_ready=0 until tick consumes first.
REQ-030 din_valid asserted same cycle as tick -> that din appears in the frame started by the tick.
REQ-031 RESET at 8th SCK of channel A -> CS=1 next cycle, LD never low, all outputs at reset values.
REQ-032 Macro undefined -> DAC_LD constant 0, busy drops one cycle after channel B CS_HOLD.
